// File: rtl/uart_debug_ctrl.sv
// uart_debug_ctrl: UART command sequencer that loads instruction memory and runs/steps the core
module uart_debug_ctrl #(
  parameter int             NB_DATA  = 32,
  parameter int             NB_BYTE  = 8,
  parameter int             NB_ADDR  = 10,
  parameter logic [NB_BYTE-1:0] CMD_LOAD = 8'h4C,
  parameter logic [NB_BYTE-1:0] CMD_RUN  = 8'h52,
  parameter logic [NB_BYTE-1:0] CMD_STEP = 8'h53,
  parameter logic [NB_BYTE-1:0] ACK      = 8'h06,
  parameter logic [NB_BYTE-1:0] NAK      = 8'h15
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx_done,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_tx_done,
  input  logic               i_cpu_halt,
  input  logic [NB_DATA-1:0] i_pc,
  output logic               o_tx_start,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_imem_we,
  output logic [NB_ADDR-1:0] o_imem_addr,
  output logic [NB_DATA-1:0] o_imem_data,
  output logic               o_cpu_en
);
  localparam int NB_PAY = NB_DATA / NB_BYTE;
  localparam int NB_CNT = $clog2(NB_PAY + 1);
  localparam logic [NB_DATA-1:0] ACK_PAY = {ACK, {(NB_DATA-NB_BYTE){1'b0}}};
  localparam logic [NB_DATA-1:0] NAK_PAY = {NAK, {(NB_DATA-NB_BYTE){1'b0}}};
  typedef enum logic [2:0] {IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WR, RUN, STEP, SEND, SEND_WAIT} state_t;
  state_t              state;
  logic [NB_BYTE-1:0]  word_cnt;
  logic [NB_CNT-1:0]   byte_cnt;
  logic [NB_CNT-1:0]   tx_left;
  logic [NB_DATA-1:0]  payload;
  // Command sequencer; the load shift register doubles as o_imem_data and the address counter as o_imem_addr
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= IDLE;
      word_cnt    <= '0;
      byte_cnt    <= '0;
      tx_left     <= '0;
      payload     <= '0;
      o_tx_start  <= 1'b0;
      o_tx_data   <= '0;
      o_imem_we   <= 1'b0;
      o_imem_addr <= '0;
      o_imem_data <= '0;
      o_cpu_en    <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_imem_we  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_rx_done) begin
            if (i_rx_data == CMD_LOAD) begin
              state <= LOAD_CNT;
            end else if (i_rx_data == CMD_RUN) begin
              if (i_cpu_halt) begin
                payload <= i_pc;
                tx_left <= NB_CNT'(NB_PAY);
                state   <= SEND;
              end else begin
                o_cpu_en <= 1'b1;
                state    <= RUN;
              end
            end else if (i_rx_data == CMD_STEP) begin
              o_cpu_en <= 1'b1;
              state    <= STEP;
            end else begin
              payload <= NAK_PAY;
              tx_left <= NB_CNT'(1);
              state   <= SEND;
            end
          end
        end
        LOAD_CNT: begin
          if (i_rx_done) begin
            if (i_rx_data == '0) begin
              payload <= ACK_PAY;
              tx_left <= NB_CNT'(1);
              state   <= SEND;
            end else begin
              word_cnt    <= i_rx_data;
              o_imem_addr <= '0;
              byte_cnt    <= '0;
              state       <= LOAD_BYTE;
            end
          end
        end
        LOAD_BYTE: begin
          if (i_rx_done) begin
            o_imem_data <= {o_imem_data[NB_DATA-NB_BYTE-1:0], i_rx_data};
            if (byte_cnt == NB_CNT'(NB_PAY - 1)) begin
              byte_cnt  <= '0;
              o_imem_we <= 1'b1;
              state     <= LOAD_WR;
            end else begin
              byte_cnt <= byte_cnt + NB_CNT'(1);
            end
          end
        end
        LOAD_WR: begin
          o_imem_addr <= o_imem_addr + NB_ADDR'(1);
          word_cnt    <= word_cnt - NB_BYTE'(1);
          if (word_cnt == NB_BYTE'(1)) begin
            payload <= ACK_PAY;
            tx_left <= NB_CNT'(1);
            state   <= SEND;
          end else begin
            state <= LOAD_BYTE;
          end
        end
        RUN: begin
          if (i_cpu_halt) begin
            o_cpu_en <= 1'b0;
            payload  <= i_pc;
            tx_left  <= NB_CNT'(NB_PAY);
            state    <= SEND;
          end
        end
        STEP: begin
          if (o_cpu_en) begin
            o_cpu_en <= 1'b0;
          end else begin
            payload <= i_pc;
            tx_left <= NB_CNT'(NB_PAY);
            state   <= SEND;
          end
        end
        SEND: begin
          o_tx_start <= 1'b1;
          o_tx_data  <= payload[NB_DATA-1 -: NB_BYTE];
          payload    <= payload << NB_BYTE;
          tx_left    <= tx_left - NB_CNT'(1);
          state      <= SEND_WAIT;
        end
        SEND_WAIT: begin
          if (i_tx_done) state <= (tx_left != '0) ? SEND : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_debug_ctrl.sv
// tb_uart_debug_ctrl: directed table and sequence checks of the UART debug controller
module tb_uart_debug_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        tx_done = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] pc;
  logic        tx_start, imem_we, cpu_en;
  logic [7:0]  tx_data;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data;
  int checks = 0, errors = 0;
  int starts = 0, dones = 0, en_cyc = 0, en_snap = 0;
  logic        freeze = 1'b1;
  logic [31:0] pc_fix = '0, pc_base = '0;
  logic [7:0]  tx_q[$];
  logic [41:0] wr_q[$];
  typedef struct { logic [7:0] b0; logic [7:0] b1; int nb; logic [7:0] exp; } vec_t;
  vec_t tbl[5];
  assign pc = freeze ? pc_fix : pc_base + 32'(4 * (en_cyc - en_snap));
  uart_debug_ctrl dut (
    .i_clk(clk), .i_reset(rst_n), .i_rx_done(rx_done), .i_rx_data(rx_data),
    .i_tx_done(tx_done), .i_cpu_halt(halt), .i_pc(pc),
    .o_tx_start(tx_start), .o_tx_data(tx_data), .o_imem_we(imem_we),
    .o_imem_addr(imem_addr), .o_imem_data(imem_data), .o_cpu_en(cpu_en)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Observe DUT outputs on the falling edge
  always @(negedge clk) begin
    if (tx_start) begin
      chk("tx_start_gated", 64'(starts - dones), 64'd0);
      tx_q.push_back(tx_data);
      starts++;
    end
    if (imem_we) wr_q.push_back({imem_addr, imem_data});
    if (cpu_en) en_cyc++;
  end
  // Transmitter model: finishes each byte a few cycles after start
  always begin
    @(negedge clk);
    if (tx_start) begin
      repeat (3) @(negedge clk);
      tx_done = 1'b1;
      dones++;
      @(negedge clk);
      tx_done = 1'b0;
    end
  end
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic wait_tx(input int n);
    int t = 0;
    while (!(tx_q.size() >= n && starts == dones) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      checks++;
      errors++;
      $display("FAIL tx_timeout: got %0d bytes expected %0d", tx_q.size(), n);
    end
    repeat (4) @(negedge clk);
  endtask
  task automatic expect_pc_tx(input string name, input logic [31:0] v);
    wait_tx(4);
    chk({name, "_count"}, 64'(tx_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk(name, (tx_q.size() > 0) ? 64'(tx_q.pop_front()) : 64'hx, 64'(v[31-8*i -: 8]));
    tx_q.delete();
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int w0, e0;
    tbl[0] = '{8'h7A, 8'h00, 1, 8'h15};
    tbl[1] = '{8'h00, 8'h00, 1, 8'h15};
    tbl[2] = '{8'hFF, 8'h00, 1, 8'h15};
    tbl[3] = '{8'h4C, 8'h00, 2, 8'h06};
    tbl[4] = '{8'h41, 8'h00, 1, 8'h15};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_tx_start", 64'(tx_start), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_imem_we", 64'(imem_we), 64'd0);
    chk("rst_imem_addr", 64'(imem_addr), 64'd0);
    chk("rst_imem_data", 64'(imem_data), 64'd0);
    chk("rst_cpu_en", 64'(cpu_en), 64'd0);
    chk("rst_no_tx", 64'(tx_q.size()), 64'd0);
    for (int i = 0; i < 5; i++) begin
      w0 = wr_q.size();
      e0 = en_cyc;
      send_byte(tbl[i].b0);
      if (tbl[i].nb == 2) send_byte(tbl[i].b1);
      wait_tx(1);
      chk($sformatf("vec%0d_tx_count", i), 64'(tx_q.size()), 64'd1);
      chk($sformatf("vec%0d_tx", i), (tx_q.size() > 0) ? 64'(tx_q[0]) : 64'hx, 64'(tbl[i].exp));
      chk($sformatf("vec%0d_no_write", i), 64'(wr_q.size() - w0), 64'd0);
      chk($sformatf("vec%0d_no_cpu_en", i), 64'(en_cyc - e0), 64'd0);
      tx_q.delete();
    end
    w0 = wr_q.size();
    send_byte(8'h4C); send_byte(8'h02);
    send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'hAC); send_byte(8'h09); send_byte(8'h00); send_byte(8'h00);
    wait_tx(1);
    chk("load_write_count", 64'(wr_q.size() - w0), 64'd2);
    chk("load_write0", (wr_q.size() > w0) ? 64'(wr_q[w0]) : 64'hx, 64'({10'd0, 32'h20080005}));
    chk("load_write1", (wr_q.size() > w0 + 1) ? 64'(wr_q[w0+1]) : 64'hx, 64'({10'd1, 32'hAC090000}));
    chk("load_ack", (tx_q.size() > 0) ? 64'(tx_q[0]) : 64'hx, 64'h06);
    tx_q.delete();
    freeze = 1'b1;
    pc_fix = 32'h0000003C;
    e0 = en_cyc;
    send_byte(8'h52);
    repeat (50) @(negedge clk);
    halt = 1'b1;
    chk("run_en_before_halt", 64'(cpu_en), 64'd1);
    @(negedge clk);
    chk("run_en_after_halt", 64'(cpu_en), 64'd0);
    chk("run_en_cycles", 64'(en_cyc - e0), 64'd53);
    expect_pc_tx("run_pc", 32'h0000003C);
    e0 = en_cyc;
    pc_fix = 32'h00000ABC;
    send_byte(8'h52);
    expect_pc_tx("run_halted_pc", 32'h00000ABC);
    chk("run_halted_no_en", 64'(en_cyc - e0), 64'd0);
    halt = 1'b0;
    pc_base = 32'h10;
    en_snap = en_cyc;
    freeze = 1'b0;
    send_byte(8'h53);
    expect_pc_tx("step_pc", 32'h00000014);
    chk("step_en_cycles", 64'(en_cyc - en_snap), 64'd1);
    freeze = 1'b1;
    w0 = wr_q.size();
    send_byte(8'h4C); send_byte(8'h01); send_byte(8'h11); send_byte(8'h22);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_imem_data", 64'(imem_data), 64'd0);
    chk("abort_imem_addr", 64'(imem_addr), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_write", 64'(wr_q.size() - w0), 64'd0);
    send_byte(8'h4C); send_byte(8'h01);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    wait_tx(1);
    chk("abort_write_count", 64'(wr_q.size() - w0), 64'd1);
    chk("abort_write", (wr_q.size() > w0) ? 64'(wr_q[w0]) : 64'hx, 64'({10'd0, 32'hDEADBEEF}));
    chk("abort_ack", (tx_q.size() > 0) ? 64'(tx_q[0]) : 64'hx, 64'h06);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_debug_ctrl.md
Name: uart_debug_ctrl

Overview:
- Command sequencer between the UART (rx/tx byte interfaces) and the MIPS core.
- Decodes single-byte commands from the host: load a program into instruction memory, run the core until halt, or single-step it.
- Returns status and PC bytes to the host over the UART transmitter.
- Sits in top between the UART and the core/instruction-memory write port. While the controller is in any state other than RUN/STEP, the core is frozen (o_cpu_en=0).

Parameters:
NB_DATA, 32, instruction/PC width (must be a multiple of 8)
NB_BYTE, 8, UART byte width
NB_ADDR, 10, instruction-memory word-address width
CMD_LOAD, 8'h4C, load-program command ('L')
CMD_RUN, 8'h52, run command ('R')
CMD_STEP, 8'h53, step command ('S')
ACK, 8'h06, load-complete response
NAK, 8'h15, unknown-command response

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-low reset
i_rx_done  in  1  one-cycle pulse, i_rx_data valid
i_rx_data  in  NB_BYTE  received byte
i_tx_done  in  1  one-cycle pulse, transmitter finished current byte
i_cpu_halt  in  1  core has executed HALT (level)
i_pc  in  NB_DATA  current core PC
o_tx_start  out  1  one-cycle pulse, start transmitting o_tx_data
o_tx_data  out  NB_BYTE  byte to transmit, held stable until i_tx_done
o_imem_we  out  1  instruction-memory write strobe (one cycle per word)
o_imem_addr  out  NB_ADDR  word address for write
o_imem_data  out  NB_DATA  word to write
o_cpu_en  out  1  core clock-enable

Behaviour:
- Reset (i_reset=0, async):
  - State goes to IDLE.
  - All outputs 0; address counter, byte counter, word counter and shift registers 0.
  - Reset mid-operation aborts the command; no partial word is written after release.
- All outputs are registered.
- States: IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WR, RUN, STEP, SEND, SEND_WAIT.
- IDLE: on i_rx_done, decode i_rx_data:
  - CMD_LOAD -> LOAD_CNT.
  - CMD_RUN -> RUN. If i_cpu_halt is already 1, go straight to SEND with i_pc latched; o_cpu_en stays 0.
  - CMD_STEP -> STEP.
  - Any other byte -> SEND with a 1-byte payload of NAK.
- LOAD_CNT: next received byte N sets the word count.
  - N=0 -> SEND with ACK; no writes occur.
  - Otherwise clear o_imem_addr and the byte counter, then go to LOAD_BYTE.
- LOAD_BYTE: each received byte shifts in MSB-first: word = {word[NB_DATA-NB_BYTE-1:0], byte}. After NB_DATA/8 bytes, go to LOAD_WR.
- LOAD_WR (one cycle):
  - o_imem_we=1 with o_imem_data = assembled word and o_imem_addr = current address.
  - Then increment the address (wrapping at 2^NB_ADDR) and decrement the word count.
  - Count reaches 0 -> SEND with ACK; otherwise -> LOAD_BYTE.
- RUN:
  - o_cpu_en=1 from the cycle after entry.
  - When i_cpu_halt is sampled 1: o_cpu_en=0 the next cycle, latch i_pc, go to SEND with a 4-byte payload.
- STEP:
  - o_cpu_en=1 for exactly one cycle.
  - The following cycle latches i_pc (post-step value) and goes to SEND with a 4-byte payload.
- SEND:
  - Pulse o_tx_start for one cycle with o_tx_data = next payload byte (PC bytes MSB first), then go to SEND_WAIT.
- SEND_WAIT:
  - o_tx_data held stable.
  - On i_tx_done: if bytes remain -> SEND, else -> IDLE.
  - o_tx_start is never issued before i_tx_done for the prior byte.
- i_rx_done in RUN, STEP, SEND or SEND_WAIT is ignored: the byte is dropped and no state change occurs.
- i_rx_done and i_tx_done in the same cycle: only i_tx_done is acted on (state is SEND_WAIT).
- o_imem_we is never asserted outside LOAD_WR. o_cpu_en is never asserted outside RUN/STEP.

Test Plan:
- Reset release, idle 20 cycles -> all outputs 0, no tx.
- Bytes 4C,02,20,08,00,05,AC,09,00,00 -> o_imem_we at addr 0 data 0x20080005, then addr 1 data 0xAC090000; then o_tx_start with 0x06.
- Bytes 4C,00 -> no o_imem_we; ACK 0x06 transmitted.
- Byte 52, i_cpu_halt raised after 50 cycles with i_pc=0x0000003C -> o_cpu_en high ~50 cycles, dropped the cycle after halt; tx 00,00,00,3C, each start gated by i_tx_done.
- Byte 53 with i_pc advancing 0x10->0x14 -> o_cpu_en exactly 1 cycle; tx 00,00,00,14.
- Byte 7A -> tx 0x15. Then 4C,01 followed by i_reset=0 after 2 data bytes, release, resend 4C,01 + 4 bytes -> single write at addr 0 with the new word only.
